// File: rtl/rv32i_uart_ctrl.sv
// rv32i_uart_ctrl: memory-mapped UART with run-time baud divisor, optional parity, one or two
// stop bits, 16x-oversampled receiver with false-start rejection, error flags, loopback and
// count-based TX/RX FIFOs.
// Ports:
//   i_clk          system clock, all logic on posedge
//   i_rst_n        synchronous active-low reset
//   i_cs1/i_we1    bus select / write enable (1 = write)
//   i_addr1        byte address (offsets relative to BASE)
//   i_in1          write data
//   o_q1           registered read data, valid the cycle after a read
//   i_rx           asynchronous serial input
//   o_tx           serial output, idle high
module rv32i_uart_ctrl #(
  parameter logic [31:0] BASE        = 32'hE0039000,
  parameter int unsigned TX_DEPTH    = 16,
  parameter int unsigned RX_DEPTH    = 16,
  parameter int unsigned DATA_BITS   = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd27
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_cs1,
  input  logic        i_we1,
  input  logic [31:0] i_addr1,
  input  logic [31:0] i_in1,
  output logic [31:0] o_q1,
  input  logic        i_rx,
  output logic        o_tx
);
  localparam int unsigned TXAW = $clog2(TX_DEPTH);
  localparam int unsigned RXAW = $clog2(RX_DEPTH);
  localparam int unsigned RXW  = DATA_BITS + 2;  // {par_err, frm_err, data}

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  // Bus decode
  logic [31:0] w_off;
  logic w_wr_tx, w_wr_stat, w_wr_ctrl, w_rd, w_rd_rx, w_unused;
  assign w_off     = i_addr1 - BASE;
  assign w_rd      = i_cs1 & ~i_we1;
  assign w_wr_tx   = i_cs1 & i_we1 & (w_off == 32'h00);
  assign w_wr_stat = i_cs1 & i_we1 & (w_off == 32'h08);
  assign w_wr_ctrl = i_cs1 & i_we1 & (w_off == 32'h0C);
  assign w_rd_rx   = w_rd & (w_off == 32'h04);
  assign w_unused  = ^i_in1[31:20];

  // CTRL: [15:0] div, [16] parEn, [17] parOdd, [18] stop2, [19] loopback
  logic [19:0] r_ctrl;
  logic [15:0] r_tick_cnt;
  logic        w_tick;
  assign w_tick = (r_tick_cnt == r_ctrl[15:0]);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_ctrl     <= {4'b0, DEFAULT_DIV};
      r_tick_cnt <= '0;
    end else begin
      if (w_wr_ctrl) r_ctrl <= i_in1[19:0];
      // A CTRL write restarts the divider so a new div takes effect cleanly.
      if (w_wr_ctrl || w_tick) r_tick_cnt <= '0;
      else                     r_tick_cnt <= r_tick_cnt + 16'd1;
    end
  end

  // TX FIFO
  logic [DATA_BITS-1:0] r_tx_mem [TX_DEPTH];
  logic [TXAW-1:0]      r_tx_wp, r_tx_rp;
  logic [8:0]           r_tx_cnt;
  logic w_tx_empty, w_tx_full, w_tx_push, w_tx_pop;
  logic [DATA_BITS-1:0] w_tx_head;
  assign w_tx_empty = (r_tx_cnt == 9'd0);
  assign w_tx_full  = (r_tx_cnt == 9'(TX_DEPTH));
  assign w_tx_push  = w_wr_tx & (~w_tx_full | w_tx_pop);
  assign w_tx_head  = r_tx_mem[r_tx_rp];

  always_ff @(posedge i_clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wp] <= i_in1[DATA_BITS-1:0];
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_tx_wp <= '0; r_tx_rp <= '0; r_tx_cnt <= '0;
    end else begin
      if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
      if (w_tx_pop)  r_tx_rp <= r_tx_rp + 1'b1;
      if (w_tx_push && !w_tx_pop)      r_tx_cnt <= r_tx_cnt + 9'd1;
      else if (w_tx_pop && !w_tx_push) r_tx_cnt <= r_tx_cnt - 9'd1;
    end
  end

  // TX FSM
  state_e               r_tx_st, w_tx_st_d;
  logic [3:0]           r_tx_sub, w_tx_sub_d;
  logic [2:0]           r_tx_idx, w_tx_idx_d;
  logic [DATA_BITS-1:0] r_tx_sh, w_tx_sh_d;
  logic r_tx_par, w_tx_par_d, r_tx_paren, w_tx_paren_d, r_tx_stop2, w_tx_stop2_d, w_tx_start;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_tx_st <= StIdle; r_tx_sub <= '0; r_tx_idx <= '0; r_tx_sh <= '0;
      r_tx_par <= 1'b0; r_tx_paren <= 1'b0; r_tx_stop2 <= 1'b0;
    end else begin
      r_tx_st <= w_tx_st_d; r_tx_sub <= w_tx_sub_d; r_tx_idx <= w_tx_idx_d;
      r_tx_sh <= w_tx_sh_d; r_tx_par <= w_tx_par_d; r_tx_paren <= w_tx_paren_d;
      r_tx_stop2 <= w_tx_stop2_d;
    end
  end

  always_comb begin
    w_tx_st_d = r_tx_st; w_tx_sub_d = r_tx_sub; w_tx_idx_d = r_tx_idx; w_tx_sh_d = r_tx_sh;
    w_tx_par_d = r_tx_par; w_tx_paren_d = r_tx_paren; w_tx_stop2_d = r_tx_stop2;
    w_tx_start = 1'b0;
    if (r_tx_st == StIdle) begin
      // Frames start on a tick so every bit spans exactly 16 ticks.
      w_tx_start = w_tick & ~w_tx_empty;
    end else if (w_tick) begin
      w_tx_sub_d = r_tx_sub + 4'd1;
      if (r_tx_sub == 4'hF) begin
        case (r_tx_st)
          StStart: begin w_tx_st_d = StData; w_tx_idx_d = '0; end
          StData: begin
            w_tx_sh_d = r_tx_sh >> 1;
            if (r_tx_idx == 3'(DATA_BITS - 1)) begin
              w_tx_st_d  = r_tx_paren ? StParity : StStop;
              w_tx_idx_d = '0;
            end else begin
              w_tx_idx_d = r_tx_idx + 3'd1;
            end
          end
          StParity: w_tx_st_d = StStop;
          StStop: begin
            if (r_tx_stop2 && r_tx_idx == 3'd0) begin
              w_tx_idx_d = 3'd1;
            end else begin
              w_tx_st_d  = StIdle;
              w_tx_start = ~w_tx_empty;  // back-to-back: no idle gap
            end
          end
          default: w_tx_st_d = StIdle;
        endcase
      end
    end
    if (w_tx_start) begin
      w_tx_st_d    = StStart;
      w_tx_sub_d   = '0;
      w_tx_sh_d    = w_tx_head;
      w_tx_paren_d = r_ctrl[16];
      w_tx_par_d   = r_ctrl[17] ? ~^w_tx_head : ^w_tx_head;
      w_tx_stop2_d = r_ctrl[18];
    end
  end
  assign w_tx_pop = w_tx_start;

  always_comb begin
    case (r_tx_st)
      StStart:  o_tx = 1'b0;
      StData:   o_tx = r_tx_sh[0];
      StParity: o_tx = r_tx_par;
      default:  o_tx = 1'b1;
    endcase
  end

  // RX synchroniser; loopback replaces the pin with the transmitter output.
  logic [1:0] r_sync;
  logic       w_rxs;
  assign w_rxs = r_sync[1];
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_sync <= 2'b11;
    else          r_sync <= {r_sync[0], r_ctrl[19] ? o_tx : i_rx};
  end

  // RX FSM
  state_e               r_rx_st, w_rx_st_d;
  logic [3:0]           r_rx_sub, w_rx_sub_d;
  logic [2:0]           r_rx_idx, w_rx_idx_d;
  logic [DATA_BITS-1:0] r_rx_sh, w_rx_sh_d;
  logic r_rx_perr, w_rx_perr_d, w_rx_push, w_rx_frm;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rx_st <= StIdle; r_rx_sub <= '0; r_rx_idx <= '0; r_rx_sh <= '0; r_rx_perr <= 1'b0;
    end else begin
      r_rx_st <= w_rx_st_d; r_rx_sub <= w_rx_sub_d; r_rx_idx <= w_rx_idx_d;
      r_rx_sh <= w_rx_sh_d; r_rx_perr <= w_rx_perr_d;
    end
  end

  always_comb begin
    w_rx_st_d = r_rx_st; w_rx_sub_d = r_rx_sub; w_rx_idx_d = r_rx_idx;
    w_rx_sh_d = r_rx_sh; w_rx_perr_d = r_rx_perr;
    w_rx_push = 1'b0; w_rx_frm = 1'b0;
    if (r_rx_st == StIdle) begin
      if (!w_rxs) begin w_rx_st_d = StStart; w_rx_sub_d = '0; end
    end else if (w_tick) begin
      w_rx_sub_d = r_rx_sub + 4'd1;
      if (r_rx_sub == 4'd7) begin  // mid-bit sample point
        case (r_rx_st)
          StStart:  if (w_rxs) w_rx_st_d = StIdle;  // false start
          StData:   w_rx_sh_d = {w_rxs, r_rx_sh[DATA_BITS-1:1]};
          StParity: w_rx_perr_d = w_rxs ^ (r_ctrl[17] ? ~^r_rx_sh : ^r_rx_sh);
          StStop: begin
            // Push at mid-stop so a following start bit is not missed.
            w_rx_push = 1'b1; w_rx_frm = ~w_rxs; w_rx_st_d = StIdle;
          end
          default: w_rx_st_d = StIdle;
        endcase
      end else if (r_rx_sub == 4'hF) begin
        case (r_rx_st)
          StStart: begin w_rx_st_d = StData; w_rx_idx_d = '0; w_rx_perr_d = 1'b0; end
          StData: begin
            if (r_rx_idx == 3'(DATA_BITS - 1)) w_rx_st_d = r_ctrl[16] ? StParity : StStop;
            else                                w_rx_idx_d = r_rx_idx + 3'd1;
          end
          StParity: w_rx_st_d = StStop;
          default: ;
        endcase
      end
    end
  end

  // RX FIFO
  logic [RXW-1:0]  r_rx_mem [RX_DEPTH];
  logic [RXAW-1:0] r_rx_wp, r_rx_rp;
  logic [8:0]      r_rx_cnt;
  logic            r_overrun;
  logic w_rx_empty, w_rx_full, w_rx_pop, w_rx_wr;
  logic [RXW-1:0]  w_rx_head;
  assign w_rx_empty = (r_rx_cnt == 9'd0);
  assign w_rx_full  = (r_rx_cnt == 9'(RX_DEPTH));
  assign w_rx_pop   = w_rd_rx & ~w_rx_empty;
  assign w_rx_wr    = w_rx_push & (~w_rx_full | w_rx_pop);
  assign w_rx_head  = r_rx_mem[r_rx_rp];

  always_ff @(posedge i_clk) begin
    if (w_rx_wr) r_rx_mem[r_rx_wp] <= {r_rx_perr, w_rx_frm, r_rx_sh};
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rx_wp <= '0; r_rx_rp <= '0; r_rx_cnt <= '0; r_overrun <= 1'b0;
    end else begin
      if (w_rx_wr)  r_rx_wp <= r_rx_wp + 1'b1;
      if (w_rx_pop) r_rx_rp <= r_rx_rp + 1'b1;
      if (w_rx_wr && !w_rx_pop)      r_rx_cnt <= r_rx_cnt + 9'd1;
      else if (w_rx_pop && !w_rx_wr) r_rx_cnt <= r_rx_cnt - 9'd1;
      if (w_rx_push && !w_rx_wr)          r_overrun <= 1'b1;
      else if (w_wr_stat && i_in1[4])     r_overrun <= 1'b0;
    end
  end

  // Registered read port
  logic [31:0] w_q_d;
  always_comb begin
    w_q_d = '0;
    if (w_rd) begin
      case (w_off)
        32'h04: if (!w_rx_empty) w_q_d = {22'b0, w_rx_head[RXW-1:RXW-2],
                                          8'(w_rx_head[DATA_BITS-1:0])};
        32'h08: w_q_d = {26'b0, (r_tx_st != StIdle), r_overrun, w_rx_full, w_rx_empty,
                         w_tx_full, w_tx_empty};
        32'h0C: w_q_d = {12'b0, r_ctrl};
        32'h10: w_q_d = {7'b0, r_rx_cnt, 7'b0, r_tx_cnt};
        default: w_q_d = '0;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) o_q1 <= '0;
    else          o_q1 <= w_q_d;
  end
endmodule
